// File: rtl/spio_hss_multiplexer_common_pkg.sv
// Shared HSS multiplexer symbols: K-characters, idle-frame layout and protocol version.
// Also provides word builders so every block forms control frames identically.
package spio_hss_multiplexer_common;

    localparam logic [7:0] KCH_COMMA     = 8'hBC;  // K28.5
    localparam logic [7:0] KCH_HANDSHAKE = 8'h5C;  // K28.2
    localparam logic [7:0] KCH_IDLE      = 8'h3C;  // K28.1
    localparam logic [7:0] KCH_CLKC      = 8'hF7;  // K23.7

    localparam int         IDLE_BITS  = 24;
    localparam logic [3:0] IDLE_KBITS = 4'b1000;

    localparam logic [7:0] PROTOCOL_VERSION = 8'h01;

    localparam int CLKC_BURST_BITS = 4;

    function automatic logic [31:0] handshake_word(input logic phase);
        return {KCH_COMMA, KCH_HANDSHAKE, 7'b0, phase, PROTOCOL_VERSION};
    endfunction

    function automatic logic [31:0] clkc_word();
        return {4{KCH_CLKC}};
    endfunction

    function automatic logic [31:0] idle_word(input logic [IDLE_BITS-1:0] payload);
        return {KCH_IDLE, payload};
    endfunction

endpackage

// File: rtl/spio_hss_multiplexer_clkc_timer.sv
// Clock-correction scheduler: interval counter plus burst counter.
// burst_load pulses in the last cycle of each interval; burst_active is high while words remain.
module spio_hss_multiplexer_clkc_timer
    import spio_hss_multiplexer_common::*;
#(
    parameter int CLKC_INTERVAL_BITS  = 16,
    parameter int CLKC_LEN            = 2,
    parameter int CLKC_INTERVAL_RESET = 1000
) (
    input  logic                          CLK_IN,
    input  logic                          RESET_IN,
    input  logic [CLKC_INTERVAL_BITS-1:0] REG_CCI_IN,
    output logic                          burst_active,
    output logic                          burst_load
);

    localparam logic [CLKC_INTERVAL_BITS-1:0] RESET_IVL =
        CLKC_INTERVAL_BITS'(CLKC_INTERVAL_RESET);
    localparam logic [CLKC_INTERVAL_BITS-1:0] MIN_IVL =
        CLKC_INTERVAL_BITS'(CLKC_LEN + 1);
    localparam logic [CLKC_INTERVAL_BITS-1:0] IVL_ONE =
        CLKC_INTERVAL_BITS'(1);
    localparam logic [CLKC_BURST_BITS-1:0] BURST_LEN =
        CLKC_BURST_BITS'(CLKC_LEN);
    localparam logic [CLKC_BURST_BITS-1:0] BURST_ONE =
        CLKC_BURST_BITS'(1);

    logic [CLKC_INTERVAL_BITS-1:0] interval_cnt;
    logic [CLKC_INTERVAL_BITS-1:0] eff_ivl;
    logic [CLKC_BURST_BITS-1:0]    burst_cnt;
    logic                          enabled;

    // Interval never shorter than a burst plus one word, so bursts cannot overlap.
    always_comb begin
        eff_ivl = REG_CCI_IN;
        if (REG_CCI_IN == '1) begin
            eff_ivl = RESET_IVL;
        end
        if (eff_ivl < MIN_IVL) begin
            eff_ivl = MIN_IVL;
        end
    end

    assign enabled      = (REG_CCI_IN != '0);
    assign burst_load   = enabled && (interval_cnt >= (eff_ivl - IVL_ONE));
    assign burst_active = (burst_cnt != '0);

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            interval_cnt <= '0;
        end else if (!enabled || burst_load) begin
            interval_cnt <= '0;
        end else begin
            interval_cnt <= interval_cnt + IVL_ONE;
        end
    end

    // A disabled interval still lets the current burst run to completion.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            burst_cnt <= '0;
        end else if (burst_load) begin
            burst_cnt <= BURST_LEN;
        end else if (burst_active) begin
            burst_cnt <= burst_cnt - BURST_ONE;
        end
    end

endmodule

// File: rtl/spio_hss_multiplexer_tx_scheduler.sv
// Transmit word scheduler: picks clock-correction, handshake, data or idle for each
// transceiver word and registers it together with its K-character flags.
module spio_hss_multiplexer_tx_scheduler
    import spio_hss_multiplexer_common::*;
#(
    parameter int CLKC_INTERVAL_BITS  = 16,
    parameter int CLKC_LEN            = 2,
    parameter int CLKC_INTERVAL_RESET = 1000
) (
    input  logic                          CLK_IN,
    input  logic                          RESET_IN,
    input  logic [IDLE_BITS-1:0]          REG_IDSO_IN,
    input  logic [CLKC_INTERVAL_BITS-1:0] REG_CCI_IN,
    input  logic                          HANDSHAKE_COMPLETE_IN,
    input  logic                          HANDSHAKE_PHASE_IN,
    output logic [31:0]                   TXDATA_OUT,
    output logic [3:0]                    TXCHARISK_OUT,
    input  logic [31:0]                   TXDATA_IN,
    input  logic [3:0]                    TXCHARISK_IN,
    input  logic                          TXVLD_IN,
    output logic                          TXRDY_OUT,
    output logic                          CLKC_ACTIVE_OUT
);

    typedef enum logic {
        ST_HS  = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic        burst_active;
    logic        burst_load;
    logic        accept;
    logic [31:0] word_next;
    logic [3:0]  kbits_next;

    spio_hss_multiplexer_clkc_timer #(
        .CLKC_INTERVAL_BITS (CLKC_INTERVAL_BITS),
        .CLKC_LEN           (CLKC_LEN),
        .CLKC_INTERVAL_RESET(CLKC_INTERVAL_RESET)
    ) u_clkc_timer (
        .CLK_IN      (CLK_IN),
        .RESET_IN    (RESET_IN),
        .REG_CCI_IN  (REG_CCI_IN),
        .burst_active(burst_active),
        .burst_load  (burst_load)
    );

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state <= ST_HS;
        end else begin
            state <= state_next;
        end
    end

    // Upstream handshake: a word transfers in any cycle where TXVLD_IN and TXRDY_OUT
    // are both high; TXRDY_OUT depends only on registered state, never on TXVLD_IN.
    always_comb begin
        state_next = state;
        TXRDY_OUT  = 1'b0;
        if (HANDSHAKE_COMPLETE_IN) begin
            state_next = ST_RUN;
        end else begin
            state_next = ST_HS;
        end
        if ((state == ST_RUN) && !burst_active) begin
            TXRDY_OUT = 1'b1;
        end
    end

    assign accept = TXVLD_IN && TXRDY_OUT;

    always_comb begin
        word_next  = idle_word(REG_IDSO_IN);
        kbits_next = IDLE_KBITS;
        if (burst_active) begin
            word_next  = clkc_word();
            kbits_next = 4'b1111;
        end else if (state == ST_HS) begin
            word_next  = handshake_word(HANDSHAKE_PHASE_IN);
            kbits_next = 4'b1100;
        end else if (accept) begin
            word_next  = TXDATA_IN;
            kbits_next = TXCHARISK_IN;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            TXDATA_OUT      <= '0;
            TXCHARISK_OUT   <= '0;
            CLKC_ACTIVE_OUT <= 1'b0;
        end else begin
            TXDATA_OUT      <= word_next;
            TXCHARISK_OUT   <= kbits_next;
            CLKC_ACTIVE_OUT <= burst_active;
        end
    end

endmodule
